// File: rtl/mem_stall_ctrl.sv
// MEM-stage sequencer for variable-latency data-memory accesses.
// Drives the memory request, stalls upstream, bubbles MEM/WB.
// Ports: clk_i, rst_i (sync, active-low), MemRead_i, MemWrite_i,
//   mem_ack_i -> mem_req_o, mem_we_o, stall_o, MEMWB_flush_o,
//   stall_cnt_o (saturating stall cycles), err_o (sticky timeout).
// Optional: define MEM_TIMEOUT_EN to enable the wait timeout / ERR state.
module mem_stall_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        mem_ack_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        stall_o,
  output logic        MEMWB_flush_o,
  output logic [31:0] stall_cnt_o,
  output logic        err_o
);

`ifdef MEM_TIMEOUT_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TO_LIM =
    CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_q, wait_d;
  logic             err_q, err_d;
`else
  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic acc;
  logic req, we, stall, flush;

  assign acc = MemRead_i | MemWrite_i;

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    we      = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
`ifdef MEM_TIMEOUT_EN
    wait_d  = wait_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (acc) begin
          req = 1'b1;
          we  = MemWrite_i;
          // zero-wait ack: pass straight through
          if (!mem_ack_i) begin
            stall   = 1'b1;
            flush   = 1'b1;
            state_d = S_WAIT;
`ifdef MEM_TIMEOUT_EN
            wait_d  = CNT_W'(1);
`endif
          end
        end
      end
      S_WAIT: begin
        req = 1'b1;
        we  = MemWrite_i;
        if (mem_ack_i) begin
          state_d = S_IDLE;
        end else begin
          stall = 1'b1;
          flush = 1'b1;
`ifdef MEM_TIMEOUT_EN
          // ack on the limit cycle still completes normally
          if (wait_q == TO_LIM) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            wait_d  = wait_q + CNT_W'(1);
          end
`endif
        end
      end
`ifdef MEM_TIMEOUT_EN
      S_ERR: begin
        stall = 1'b1;
        flush = 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign stall_cnt_d = (stall && (stall_cnt_q != 32'hFFFF_FFFF))
                     ? stall_cnt_q + 32'd1
                     : stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      stall_cnt_q <= '0;
`ifdef MEM_TIMEOUT_EN
      wait_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
`ifdef MEM_TIMEOUT_EN
      wait_q      <= wait_d;
      err_q       <= err_d;
`endif
    end
  end

  // every output reads 0 while reset is asserted
  assign mem_req_o     = rst_i & req;
  assign mem_we_o      = rst_i & we;
  assign stall_o       = rst_i & stall;
  assign MEMWB_flush_o = rst_i & flush;
  assign stall_cnt_o   = rst_i ? stall_cnt_q : 32'd0;
`ifdef MEM_TIMEOUT_EN
  assign err_o         = rst_i & err_q;
`else
  assign err_o         = 1'b0;
`endif

endmodule
